m31_reduce_arbiter: RTL and testbench

Round-robin arbiter and two-stage pipeline that shares one M31 (p = 2^31-1) modular-reduction datapath between NUM_REQ requesters. Each requester presents a wide unreduced word (typically a 62-bit product of two M31 elements) with a valid/ready handshake. The block returns the canonical field element in [0, p-1], tagged with the requester index, on a single output stream with backpressure. It sits between the field multipliers and the M31 consumers, so one reducer serves several lanes.

---
 rtl/m31_reduce_arbiter.sv | 122 ++++++++++++
 tb/tb_m31_reduce_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m31_reduce_arbiter.sv
// Round-robin arbiter feeding one shared two-stage M31 (2^31-1) reduction pipeline.
// Results leave in acceptance order, tagged with the requester index.
module m31_reduce_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int IN_WIDTH = 62,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*IN_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [30:0]                  out_data,
  output logic [ID_W-1:0]              out_id,
  output logic                         busy
);

  // First fold: x = hi*2^31 + lo, and 2^31 == 1 (mod p), so x == lo + hi.
  function automatic logic [31:0] fold_p1(input logic [61:0] x);
    return {1'b0, x[30:0]} + {1'b0, x[61:31]};
  endfunction

  // Second fold plus canonical compare; the 31-bit sum cannot carry out.
  function automatic logic [30:0] canon_p2(input logic [31:0] f1);
    logic [30:0] f2;
    f2 = f1[30:0] + {30'd0, f1[31]};
    return (f2 == 31'h7FFF_FFFF) ? 31'd0 : f2;
  endfunction

  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            vld_p1_q, vld_p1_d;
  logic [ID_W-1:0] id_p1_q, id_p1_d;
  logic [31:0]     f1_p1_q, f1_p1_d;
  logic            vld_p2_q, vld_p2_d;
  logic [ID_W-1:0] id_p2_q, id_p2_d;
  logic [30:0]     data_p2_q, data_p2_d;

  logic            adv;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            accept;
  logic [IN_WIDTH-1:0] word_p0;

  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    adv       = !vld_p2_q || out_ready;
    accept    = adv && grant_found;
    word_p0   = req_data[int'(grant_idx)*IN_WIDTH +: IN_WIDTH];
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;

    rr_ptr_d  = rr_ptr_q;
    vld_p1_d  = vld_p1_q;
    id_p1_d   = id_p1_q;
    f1_p1_d   = f1_p1_q;
    vld_p2_d  = vld_p2_q;
    id_p2_d   = id_p2_q;
    data_p2_d = data_p2_q;

    if (accept) begin
      rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // p0 -> p1: arbitration and first fold
    if (adv) begin
      vld_p1_d = accept;
      if (accept) begin
        id_p1_d = grant_idx;
        f1_p1_d = fold_p1(62'(word_p0));
      end
    end

    // p1 -> p2: second fold and canonicalisation
    if (adv) begin
      vld_p2_d  = vld_p1_q;
      id_p2_d   = id_p1_q;
      data_p2_d = canon_p2(f1_p1_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      vld_p1_q  <= 1'b0;
      id_p1_q   <= '0;
      f1_p1_q   <= '0;
      vld_p2_q  <= 1'b0;
      id_p2_q   <= '0;
      data_p2_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      vld_p1_q  <= vld_p1_d;
      id_p1_q   <= id_p1_d;
      f1_p1_q   <= f1_p1_d;
      vld_p2_q  <= vld_p2_d;
      id_p2_q   <= id_p2_d;
      data_p2_q <= data_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_id    = id_p2_q;
  assign busy      = vld_p1_q || vld_p2_q;

endmodule

// File: tb/tb_m31_reduce_arbiter.sv
// Scoreboard bench for m31_reduce_arbiter: a 4-requester/62-bit instance and a
// 1-requester/32-bit instance for the narrow-width boundary.
module tb_m31_reduce_arbiter;

  localparam int NR = 4;
  localparam int W  = 62;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            out_valid;
  logic            out_ready;
  logic [30:0]     out_data;
  logic [1:0]      out_id;
  logic            busy;

  logic            req_valid2;
  logic [31:0]     req_data2;
  logic            req_ready2;
  logic            out_valid2;
  logic [30:0]     out_data2;
  logic            out_id2;
  logic            busy2;

  always #5 clk = ~clk;

  m31_reduce_arbiter #(.NUM_REQ(NR), .IN_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id), .busy(busy));

  m31_reduce_arbiter #(.NUM_REQ(1), .IN_WIDTH(32)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_data(req_data2),
    .req_ready(req_ready2), .out_valid(out_valid2), .out_ready(1'b1),
    .out_data(out_data2), .out_id(out_id2), .busy(busy2));

  typedef struct { logic [61:0] d; logic [30:0] e; } pv_t;
  typedef struct { int id; logic [30:0] e; int cyc; } sb_t;

  pv_t   pend [NR][$];
  sb_t   sb[$];
  sb_t   sb2[$];
  int    exp_grant[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  bit    lat_chk = 1'b0;
  bit    rand_rdy = 1'b0;
  logic [NR-1:0] taken;
  sb_t   acc_e, mon_e, mon2_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [30:0] mod_m31(input logic [63:0] x);
    return 31'(x % 64'h7FFF_FFFF);
  endfunction

  function automatic bit pend_empty();
    for (int i = 0; i < NR; i++) if (pend[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Requester driver: presents queued words, records accepts into the scoreboard
  initial begin
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      taken = '0;
      if (!rst) begin
        for (int i = 0; i < NR; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            taken[i] = 1'b1;
            if (exp_grant.size() > 0) chk("grant", 64'(i), 64'(exp_grant.pop_front()));
            acc_e.id  = i;
            acc_e.e   = pend[i][0].e;
            acc_e.cyc = cyc;
            sb.push_back(acc_e);
          end
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (taken[i] && pend[i].size() > 0) void'(pend[i].pop_front());
        if (pend[i].size() > 0) begin
          req_valid[i]         = 1'b1;
          req_data[i*W +: W]   = pend[i][0].d;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // Output monitor for the 4-requester instance
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid) begin
        if (sb.size() == 0) begin
          fail_now($sformatf("unexpected output data 0x%0h id %0d, expected none", out_data, out_id));
        end else if (out_ready) begin
          mon_e = sb.pop_front();
          chk("data", 64'(out_data), 64'(mon_e.e));
          chk("id", 64'(out_id), 64'(mon_e.id));
          if (lat_chk) chk("latency", 64'(cyc - mon_e.cyc), 64'd2);
        end else begin
          chk("stall data", 64'(out_data), 64'(sb[0].e));
          chk("stall id", 64'(out_id), 64'(sb[0].id));
          chk("stall req_ready", 64'(req_ready), 64'd0);
        end
      end
    end
  end

  // Output monitor for the 32-bit instance
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid2) begin
        if (sb2.size() == 0) begin
          fail_now($sformatf("unexpected output2 data 0x%0h", out_data2));
        end else begin
          mon2_e = sb2.pop_front();
          chk("w32 data", 64'(out_data2), 64'(mon2_e.e));
          chk("w32 id", 64'(out_id2), 64'd0);
          chk("w32 latency", 64'(cyc - mon2_e.cyc), 64'd2);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic push(input int id, input logic [61:0] d, input logic [30:0] e);
    pv_t p;
    p.d = d;
    p.e = e;
    pend[id].push_back(p);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    rst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NR; i++) pend[i].delete();
    exp_grant.delete();
    repeat (n) @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic drain(input int budget);
    int t = 0;
    while ((sb.size() > 0 || !pend_empty()) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) fail_now("drain timeout");
    repeat (3) @(negedge clk);
  endtask

  task automatic send2(input logic [31:0] d, input logic [30:0] e);
    int t = 0;
    sb_t s;
    req_valid2 = 1'b1;
    req_data2  = d;
    @(negedge clk);
    while (!req_ready2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready2) begin
      fail_now("w32 accept timeout");
    end else begin
      s.id = 0; s.e = e; s.cyc = cyc;
      sb2.push_back(s);
    end
    @(posedge clk);
    #1;
    req_valid2 = 1'b0;
  endtask

  initial begin
    logic [63:0] r;
    int id;
    rst = 1'b1;
    out_ready = 1'b1;
    req_valid2 = 1'b0;
    req_data2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset out_data", 64'(out_data), 64'd0);
    chk("reset out_id", 64'(out_id), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Single requester, hand-computed residues
    lat_chk = 1'b1;
    push(0, 62'h7FFF_FFFF, 31'd0);
    push(0, 62'h8000_0000, 31'd1);
    push(0, 62'h2_8000_0003, 31'd8);
    push(0, 62'h3FFF_FFFF_FFFF_FFFF, 31'd0);
    push(0, 62'h3FFF_FFFF_0000_0001, 31'd0);
    repeat (5) exp_grant.push_back(0);
    drain(200);

    // All four requesters continuously valid
    do_reset(1);
    for (int n = 0; n < 6; n++)
      for (int i = 0; i < NR; i++) begin
        r = (64'(i + 1) << 40) | 64'(n * 7 + i);
        push(i, r[61:0], mod_m31(r));
        exp_grant.push_back(i);
      end
    drain(300);

    // Only requesters 2 and 3
    do_reset(1);
    for (int n = 0; n < 2; n++) begin
      push(2, 62'h7FFF_FFFF + 62'(n), 31'(n));
      push(3, 62'h1_0000_0000 + 62'(n), 31'(2 + n));
      exp_grant.push_back(2);
      exp_grant.push_back(3);
    end
    drain(200);

    // Backpressure: 8 requests (k*2^31 + k -> 2k), 3-cycle stall mid-stream
    do_reset(1);
    lat_chk = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      push((k - 1) % NR, (62'(k) << 31) | 62'(k), 31'(2 * k));
      exp_grant.push_back((k - 1) % NR);
    end
    repeat (4) @(posedge clk);
    #2;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain(200);

    // Reset with both stages full
    lat_chk = 1'b1;
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < NR; i++) begin
        r = 64'(n * 100 + i + 3);
        push(i, r[61:0], mod_m31(r));
      end
    repeat (4) @(negedge clk);
    chk("pre-reset busy", 64'(busy && out_valid), 64'd1);
    do_reset(1);
    @(negedge clk);
    chk("post-reset out_valid", 64'(out_valid), 64'd0);
    chk("post-reset busy", 64'(busy), 64'd0);
    push(3, 62'h3FFF_FFFF_0000_0001, 31'd0);
    push(1, 62'h2_8000_0003, 31'd8);
    exp_grant.push_back(1);
    exp_grant.push_back(3);
    drain(200);

    // Random regression with random backpressure
    lat_chk = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      id = $urandom_range(0, NR - 1);
      r = {$urandom(), $urandom()};
      if (n % 50 == 0) r = 64'h3FFF_FFFF_FFFF_FFFF;
      push(id, r[61:0], mod_m31({2'b00, r[61:0]}));
    end
    rand_rdy = 1'b1;
    drain(40000);
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    // 32-bit input width, single requester
    send2(32'hFFFF_FFFF, 31'd1);
    send2(32'h7FFF_FFFE, 31'h7FFF_FFFE);
    send2(32'h7FFF_FFFF, 31'd0);
    send2(32'h8000_0000, 31'd1);
    repeat (5) @(negedge clk);
    if (sb2.size() != 0) fail_now("w32 results missing");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
